// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the sync_fifo block.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one write port, one registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = clog2_min1(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] store [DEPTH];

  // Storage write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (we) store[waddr] <= wdata;
  end

  // Registered read port; holds its value whenever no read is issued.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= store[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and count-decoded flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_WIDTH = clog2_min1(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  // rstn is active-high despite its name.
  logic                  rst;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok, rd_ok;

  assign rst   = rstn;
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A read frees a slot in the same edge, so a full FIFO still takes a
  // write when it is also being read. No fall-through when empty.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: moves only when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (rst)                 count <= '0;
    else if (wr_ok & ~rd_ok) count <= count + 1'b1;
    else if (rd_ok & ~wr_ok) count <= count - 1'b1;
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok & ~rst),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_ok & ~rst),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, then
// model-checked wrap-around and randomized traffic.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rstn, wr_en, rd_en;
  logic [DW-1:0] wdata, rdata;
  logic          full, empty;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, wr, rd;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rdata;
    logic          exp_empty, exp_full;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input int idx,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Apply inputs, let one edge pass, sample 1 time unit after it.
  task automatic drive(input logic r, input logic w, input logic rd,
                       input logic [DW-1:0] d);
    rstn = r; wr_en = w; rd_en = rd; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic w, input logic rd,
                     input logic [DW-1:0] d, input logic [DW-1:0] er,
                     input logic ee, input logic ef);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.wd = d;
    v.exp_rdata = er; v.exp_empty = ee; v.exp_full = ef;
    tbl.push_back(v);
  endtask

  // Reference model: queue of stored words, FIFO rules applied directly.
  task automatic mstep(input string name, input int idx, input logic r,
                       input logic w, input logic rd, input logic [DW-1:0] d);
    bit rok, wok;
    if (r) begin
      mq.delete();
      m_rdata = '0;
    end else begin
      rok = rd && (mq.size() != 0);
      wok = w && ((mq.size() < D) || rok);
      if (rok) m_rdata = mq.pop_front();
      if (wok) mq.push_back(d);
    end
    drive(r, w, rd, d);
    chk({name, ".rdata"}, idx, rdata, m_rdata);
    chk({name, ".empty"}, idx, {7'd0, empty}, {7'd0, mq.size() == 0});
    chk({name, ".full"},  idx, {7'd0, full},  {7'd0, mq.size() == D});
  endtask

  initial begin
    rstn = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;

    //   rst wr rd wdata   rdata  empty full
    add(1, 0, 0, 8'h00, 8'h00, 1, 0);   // reset
    add(0, 0, 0, 8'h00, 8'h00, 1, 0);   // idle after reset
    add(0, 1, 0, 8'hA5, 8'h00, 0, 0);
    add(0, 1, 0, 8'h5A, 8'h00, 0, 0);
    add(0, 0, 1, 8'h00, 8'hA5, 0, 0);   // count 1
    add(0, 1, 0, 8'hFF, 8'hA5, 0, 0);
    add(0, 1, 0, 8'h00, 8'hA5, 0, 0);
    add(0, 0, 1, 8'h00, 8'h5A, 0, 0);
    add(1, 0, 0, 8'h00, 8'h00, 1, 0);   // fill and overflow
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 8'(i), 8'h00, 0, (i == 8));
    add(0, 1, 0, 8'hEE, 8'h00, 0, 1);   // write while full ignored
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, 8'h00, 8'(i), (i == 8), 0);
    add(0, 0, 1, 8'h00, 8'h08, 1, 0);   // underflow: rdata holds
    add(0, 1, 0, 8'h77, 8'h08, 0, 0);
    add(0, 0, 1, 8'h00, 8'h77, 1, 0);
    add(0, 1, 1, 8'h33, 8'h77, 0, 0);   // rd+wr on empty: write only
    add(0, 1, 0, 8'h34, 8'h77, 0, 0);
    add(0, 1, 0, 8'h35, 8'h77, 0, 0);   // count 3
    add(0, 1, 1, 8'h40, 8'h33, 0, 0);
    add(0, 1, 1, 8'h41, 8'h34, 0, 0);
    add(0, 1, 1, 8'h42, 8'h35, 0, 0);
    add(0, 1, 1, 8'h43, 8'h40, 0, 0);   // still 3: 41 42 43
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 8'(8'h44 + i), 8'h40, 0, (i == 4));
    add(0, 1, 1, 8'h50, 8'h41, 0, 1);   // rd+wr while full stays full
    add(0, 0, 1, 8'h00, 8'h42, 0, 0);
    add(0, 0, 1, 8'h00, 8'h43, 0, 0);
    add(0, 0, 1, 8'h00, 8'h44, 0, 0);   // count 5
    add(1, 0, 0, 8'h00, 8'h00, 1, 0);   // reset mid-operation
    add(0, 1, 0, 8'h99, 8'h00, 0, 0);
    add(0, 0, 1, 8'h00, 8'h99, 1, 0);
    add(0, 0, 1, 8'h00, 8'h99, 1, 0);   // old data gone

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].wd);
      chk("tbl.rdata", i, rdata, tbl[i].exp_rdata);
      chk("tbl.empty", i, {7'd0, empty}, {7'd0, tbl[i].exp_empty});
      chk("tbl.full",  i, {7'd0, full},  {7'd0, tbl[i].exp_full});
    end

    // Wrap-around: preload 3, then 20 write/read pairs across the wrap.
    mstep("wrap", 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) mstep("wrap", 1, 0, 1, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 20; i++) begin
      mstep("wrap", 2 + 2 * i, 0, 1, 0, 8'(i * 13 + 7));
      mstep("wrap", 3 + 2 * i, 0, 0, 1, 8'h00);
    end

    // Randomized traffic with phase-dependent bias to reach full and empty.
    mstep("rand", 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 1200; i++) begin
      int  ph;
      bit  w, r, rs;
      ph = (i / 150) % 4;
      w  = ($urandom_range(99) < ((ph == 0) ? 80 : (ph == 1) ? 20 : 50));
      r  = ($urandom_range(99) < ((ph == 0) ? 20 : (ph == 1) ? 80 : 50));
      rs = ($urandom_range(199) == 0);
      mstep("rand", i + 1, rs, w, r, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, synchronous first-in/first-out buffer with a registered read data output and full/empty status flags. It is used as a general-purpose rate/elasticity buffer between a producer and a consumer in the same clock domain. Default configuration: 8-bit words, 8 entries.

Parameters:
DATA_WIDTH, 8, width of wdata/rdata and of each storage word
DEPTH, 8, number of storage entries; must be a power of two and at least 2
ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden by users

Ports:
clk  input  1  single clock; all state updates on the rising edge
rstn  input  1  synchronous, active-high reset (1 = reset); the name is kept for codebase consistency
wr_en  input  1  write request, sampled at the rising edge of clk
rd_en  input  1  read request, sampled at the rising edge of clk
wdata  input  DATA_WIDTH  write data, captured when a write is accepted
rdata  output  DATA_WIDTH  registered read data
full  output  1  high when the FIFO holds DEPTH entries
empty  output  1  high when the FIFO holds 0 entries

Behaviour:
- Reset: when rstn=1 at a rising edge, the FIFO sets write pointer=0, read pointer=0, count=0, rdata=0, empty=1, full=0. Storage contents need not be cleared. Reset has priority over wr_en and rd_en. Asserting reset mid-operation discards all stored data.
- State: wr_ptr and rd_ptr are ADDR_WIDTH wide and wrap naturally from DEPTH-1 to 0. A count register is ADDR_WIDTH+1 wide and ranges 0..DEPTH.
- Flags are combinational decodes of the registered count: empty=(count==0), full=(count==DEPTH). They change in the cycle after the edge that accepts the operation.
- Write acceptance: wr_ok = wr_en and (not full, or rd_ok). On an accepted write, mem[wr_ptr] <= wdata and wr_ptr increments by 1.
- Read acceptance: rd_ok = rd_en and not empty. On an accepted read, rdata <= mem[rd_ptr] and rd_ptr increments by 1.
- Read latency is one clock: data appears on rdata after the rising edge that accepts rd_en.
- rdata holds its last value when no read is accepted, including on a read of an empty FIFO.
- Count update: +1 if wr_ok and not rd_ok; -1 if rd_ok and not wr_ok; unchanged if both or neither.
- Write while full, with no simultaneous read: the write is ignored, with no pointer or storage change and no error flag.
- Read while empty: ignored, with no pointer change. There is no fall-through, so a simultaneous read and write on an empty FIFO performs only the write.
- Simultaneous read and write while full: both are performed and count stays at DEPTH.
- Simultaneous read and write at 0 < count < DEPTH: both are performed and count is unchanged.
- Ordering: data is strictly first-in, first-out, including across pointer wrap-around.
- X-safety: wdata is not sampled unless a write is accepted.

Decomposition:
- Shared package sync_fifo_pkg holds the default DATA_WIDTH/DEPTH localparams and a function clog2_min1 for pointer width (minimum 1).
- One sub-module, sync_fifo_mem, is natural: DEPTH x DATA_WIDTH storage with one write port and a registered read port (we, waddr, wdata, re, raddr, rdata).
- The top level holds the pointers, count, flag decode and acceptance logic.

Test Plan:
- Reset: hold rstn=1 for 1 cycle, then release -> empty=1, full=0, rdata=8'h00.
- Basic order: write 8'hA5 then 8'h5A on consecutive cycles, then one read -> rdata=8'hA5 one cycle after the read edge, empty=0, count=1. Write 8'hFF and 8'h00, then read -> rdata=8'h5A.
- Fill and overflow: write 8 values 8'h01..8'h08 -> full=1 after the 8th edge. Write 8'hEE while full -> ignored. Read all 8 -> 8'h01..8'h08 in order, then empty=1.
- Underflow: read on an empty FIFO -> rdata keeps its previous value, pointers are unchanged, and a subsequent write then read returns the written value.
- Simultaneous: with count=3, assert wr_en and rd_en for 4 cycles -> count stays 3 and outputs stay in order. With the FIFO full, a simultaneous read and write keeps full=1. With the FIFO empty, a simultaneous read and write leaves empty=0 after the edge and rdata unchanged.
- Wrap-around and reset mid-operation: 20 interleaved write/read pairs cross the pointer wrap with data intact. With count=5, assert rstn -> empty=1, rdata=0, and the next write/read returns the new data only.
